// File: rtl/serial_word_shifter.sv
// Parallel-to-serial word shifter: WIDTH-bit words on a valid/ready handshake, one bit per clk on x.
// Optional even-parity trailer bit when SERIAL_WORD_SHIFTER_PARITY_EN is defined.
module serial_word_shifter #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             x,
   output logic             x_valid,
   output logic             busy,
   output logic             word_done
);

`ifdef SERIAL_WORD_SHIFTER_PARITY_EN
   localparam int FRAME_LEN = WIDTH + 1;
`else
   localparam int FRAME_LEN = WIDTH;
`endif
   localparam int CNT_W = $clog2(FRAME_LEN);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   shreg_q, shreg_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               x_q, x_d;
   logic               x_valid_q, x_valid_d;
   logic               busy_q, busy_d;
   logic               word_done_q, word_done_d;
`ifdef SERIAL_WORD_SHIFTER_PARITY_EN
   logic               parity_q, parity_d;
`endif
   logic               last_bit;
   logic               load;

   always_comb begin
      // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
      state_d     = state_q;
      shreg_d     = shreg_q;
      cnt_d       = cnt_q;
      x_d         = x_q;
      x_valid_d   = x_valid_q;
      busy_d      = busy_q;
      word_done_d = word_done_q;
`ifdef SERIAL_WORD_SHIFTER_PARITY_EN
      parity_d    = parity_q;
`endif

      last_bit  = (state_q == SHIFT) && (cnt_q == '0);
      din_ready = (state_q == IDLE) || last_bit;
      load      = din_valid && din_ready;

      if (load) begin
         // The first bit goes straight to x; the register keeps the remaining bits.
         state_d     = SHIFT;
         cnt_d       = CNT_W'(FRAME_LEN - 1);
         x_valid_d   = 1'b1;
         busy_d      = 1'b1;
         word_done_d = 1'b0;
         if (MSB_FIRST) begin
            x_d     = din[WIDTH-1];
            shreg_d = din << 1;
         end else begin
            x_d     = din[0];
            shreg_d = din >> 1;
         end
`ifdef SERIAL_WORD_SHIFTER_PARITY_EN
         parity_d = ^din;
`endif
      end else if ((state_q == SHIFT) && !last_bit) begin
         cnt_d       = cnt_q - CNT_W'(1);
         word_done_d = (cnt_q == CNT_W'(1));
         if (MSB_FIRST) begin
            x_d     = shreg_q[WIDTH-1];
            shreg_d = shreg_q << 1;
         end else begin
            x_d     = shreg_q[0];
            shreg_d = shreg_q >> 1;
         end
`ifdef SERIAL_WORD_SHIFTER_PARITY_EN
         if (cnt_q == CNT_W'(1)) begin
            x_d = parity_q;
         end
`endif
      end else begin
         // Idle, or the last bit just left without a follow-on word: x reads as 0.
         state_d     = IDLE;
         cnt_d       = '0;
         x_d         = 1'b0;
         x_valid_d   = 1'b0;
         busy_d      = 1'b0;
         word_done_d = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         shreg_q     <= '0;
         cnt_q       <= '0;
         x_q         <= 1'b0;
         x_valid_q   <= 1'b0;
         busy_q      <= 1'b0;
         word_done_q <= 1'b0;
`ifdef SERIAL_WORD_SHIFTER_PARITY_EN
         parity_q    <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         shreg_q     <= shreg_d;
         cnt_q       <= cnt_d;
         x_q         <= x_d;
         x_valid_q   <= x_valid_d;
         busy_q      <= busy_d;
         word_done_q <= word_done_d;
`ifdef SERIAL_WORD_SHIFTER_PARITY_EN
         parity_q    <= parity_d;
`endif
      end
   end

   assign x         = x_q;
   assign x_valid   = x_valid_q;
   assign busy      = busy_q;
   assign word_done = word_done_q;

endmodule

// File: tb/tb_serial_word_shifter.sv
// Bench for serial_word_shifter: a queue-based frame model checked every cycle, plus literal bit-stream checks.
// Instance a is MSB-first, instance b is LSB-first; honours SERIAL_WORD_SHIFTER_PARITY_EN.
module tb_serial_word_shifter;
   localparam int W = 8;
`ifdef SERIAL_WORD_SHIFTER_PARITY_EN
   localparam int FL = W + 1;
   localparam logic [63:0] EXP_D0  = 64'h1A1;
   localparam logic [63:0] EXP_BTB = 64'({9'h1A1, 9'h01B});
   localparam logic [63:0] EXP_C0  = 64'h180;
   localparam logic [63:0] EXP_0B  = 64'h1A1;
`else
   localparam int FL = W;
   localparam logic [63:0] EXP_D0  = 64'hD0;
   localparam logic [63:0] EXP_BTB = 64'hD00D;
   localparam logic [63:0] EXP_C0  = 64'hC0;
   localparam logic [63:0] EXP_0B  = 64'hD0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] din_a, din_b;
   logic         valid_a, valid_b;
   logic         ready_a, x_a, xv_a, busy_a, wd_a;
   logic         ready_b, x_b, xv_b, busy_b, wd_b;

   always #5 clk = ~clk;

   serial_word_shifter #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_a (
      .clk(clk), .rst(rst), .din(din_a), .din_valid(valid_a), .din_ready(ready_a),
      .x(x_a), .x_valid(xv_a), .busy(busy_a), .word_done(wd_a));

   serial_word_shifter #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_b (
      .clk(clk), .rst(rst), .din(din_b), .din_valid(valid_b), .din_ready(ready_b),
      .x(x_b), .x_valid(xv_b), .busy(busy_b), .word_done(wd_b));

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a queue of frame bits still to appear; the head is the bit currently on x.
   bit qa[$];
   bit qb[$];
   bit ra, rb;

   function automatic bit frame_bit(input logic [W-1:0] w, input bit msb, input int i);
      if (i >= W) return ^w;
      return msb ? w[W-1-i] : w[i];
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         qa.delete();
         qb.delete();
      end else begin
         ra = (qa.size() <= 1);
         rb = (qb.size() <= 1);
         if (qa.size() > 0) void'(qa.pop_front());
         if (qb.size() > 0) void'(qb.pop_front());
         if (valid_a && ra) for (int i = 0; i < FL; i++) qa.push_back(frame_bit(din_a, 1'b1, i));
         if (valid_b && rb) for (int i = 0; i < FL; i++) qb.push_back(frame_bit(din_b, 1'b0, i));
      end
   end

   // Stream collectors feeding the literal checks.
   logic [63:0] cap_a = '0, cap_b = '0;
   int n_a = 0, n_b = 0, wdc_a = 0, rdy_a = 0, hits_a = 0;
   logic [2:0] hist_a = '0;

   always @(negedge clk) begin
      check("a_x",         x_a,     (qa.size() > 0) ? qa[0] : 1'b0);
      check("a_x_valid",   xv_a,    qa.size() > 0);
      check("a_busy",      busy_a,  qa.size() > 0);
      check("a_word_done", wd_a,    qa.size() == 1);
      check("a_din_ready", ready_a, qa.size() <= 1);
      check("b_x",         x_b,     (qb.size() > 0) ? qb[0] : 1'b0);
      check("b_x_valid",   xv_b,    qb.size() > 0);
      check("b_busy",      busy_b,  qb.size() > 0);
      check("b_word_done", wd_b,    qb.size() == 1);
      check("b_din_ready", ready_b, qb.size() <= 1);
      if (xv_a) begin
         cap_a = {cap_a[62:0], x_a};
         n_a++;
         if (wd_a) wdc_a++;
         if (ready_a) rdy_a++;
      end
      if (xv_b) begin
         cap_b = {cap_b[62:0], x_b};
         n_b++;
      end
      if ({hist_a, x_a} == 4'b1101) hits_a++;
      hist_a = {hist_a[1:0], x_a};
   end

   function automatic logic [63:0] low(input logic [63:0] v, input int n);
      return v & ((64'd1 << n) - 64'd1);
   endfunction

   task automatic send_a(input logic [W-1:0] w);
      din_a = w; valid_a = 1'b1;
      @(posedge clk); #1;
      valid_a = 1'b0; din_a = ~w;
   endtask

   task automatic send_b(input logic [W-1:0] w);
      din_b = w; valid_b = 1'b1;
      @(posedge clk); #1;
      valid_b = 1'b0; din_b = ~w;
   endtask

   int bn, bw, br, bh;

   initial begin
      rst = 1'b0; valid_a = 1'b0; valid_b = 1'b0; din_a = '0; din_b = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_x", x_a, 0);
      check("reset_x_valid", xv_a, 0);
      check("reset_din_ready", ready_a, 1);
      rst = 1'b1;

      // Idle fill
      bn = n_a;
      repeat (10) @(posedge clk);
      #1;
      check("idle_no_bits", n_a - bn, 0);

      // Basic MSB-first
      bn = n_a; bw = wdc_a; bh = hits_a;
      send_a(8'hD0);
      repeat (FL + 3) @(posedge clk);
      #1;
      check("basic_len", n_a - bn, FL);
      check("basic_bits", low(cap_a, FL), EXP_D0);
      check("basic_word_done", wdc_a - bw, 1);
      check("basic_1101_hits", hits_a - bh, 1);

      // Back-to-back with valid held high
      bn = n_a; bw = wdc_a; br = rdy_a;
      din_a = 8'hD0; valid_a = 1'b1;
      @(posedge clk); #1;
      din_a = 8'h0D;
      repeat (FL) @(posedge clk);
      #1;
      valid_a = 1'b0; din_a = '0;
      repeat (FL + 3) @(posedge clk);
      #1;
      check("btb_len", n_a - bn, 2 * FL);
      check("btb_bits", low(cap_a, 2 * FL), EXP_BTB);
      check("btb_word_done", wdc_a - bw, 2);
      check("btb_ready_cycles", rdy_a - br, 2);

      // LSB-first
      bn = n_b;
      send_b(8'h0B);
      repeat (FL + 3) @(posedge clk);
      #1;
      check("lsb_len", n_b - bn, FL);
      check("lsb_bits", low(cap_b, FL), EXP_0B);

      // Word with even number of ones
      bn = n_a;
      send_a(8'hC0);
      repeat (FL + 3) @(posedge clk);
      #1;
      check("c0_bits", low(cap_a, FL), EXP_C0);
      check("c0_len", n_a - bn, FL);

      // Reset mid-word, three bits into 8'hFF
      send_a(8'hFF);
      repeat (2) @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      check("midrst_x", x_a, 0);
      check("midrst_x_valid", xv_a, 0);
      check("midrst_busy", busy_a, 0);
      check("midrst_word_done", wd_a, 0);
      bn = n_a;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (FL + 2) @(posedge clk);
      #1;
      check("midrst_no_residual", n_a - bn, 0);

      // Fresh transfer after reset
      bn = n_a;
      send_a(8'hD0);
      repeat (FL + 3) @(posedge clk);
      #1;
      check("post_rst_bits", low(cap_a, FL), EXP_D0);
      check("post_rst_len", n_a - bn, FL);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/serial_word_shifter.md
Name: serial_word_shifter

Overview:
- Parallel-to-serial stage that directly feeds the serial bit pattern detectors, such as the 1101 Moore detector on input x.
- Accepts WIDTH-bit words on a valid/ready handshake and emits them one bit per clk on x.
- Supports back-to-back words with no bubble cycle, so consecutive words form one continuous bit stream. This lets the detector catch patterns that straddle word boundaries.
- Drives x low when idle, so idle cycles look like a run of 0 bits to the detector.

Parameters:
- WIDTH, 8, data word width in bits; legal range 2..32.
- MSB_FIRST, 1, 1: bit WIDTH-1 is sent first; 0: bit 0 is sent first.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- din  input  WIDTH  parallel word to serialize.
- din_valid  input  1  din holds a word to send.
- din_ready  output  1  block can accept a word this cycle.
- x  output  1  serial data bit (registered).
- x_valid  output  1  x carries a frame bit this cycle (registered).
- busy  output  1  high in SHIFT state.
- word_done  output  1  one-cycle pulse, high while the last bit of a frame is on x.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, shift register=0, bit counter=0.
  - x=0, x_valid=0, busy=0, word_done=0.
  - A word in flight is discarded. No residual bits appear after release.
- States: IDLE and SHIFT.
- Handshake:
  - A transfer occurs on a rising edge with din_valid=1 and din_ready=1.
  - din_ready is combinational: 1 in IDLE; 1 in SHIFT only when the last frame bit is on x; else 0.
  - din_ready reads 1 while rst=0, but no transfer is taken during reset.
  - din_valid may deassert at any time without penalty. din is sampled only on the transfer edge.
- Latency:
  - The first frame bit is on x and x_valid=1 in the cycle after the transfer edge.
  - Each later bit follows on the next consecutive cycle.
- IDLE to SHIFT on a transfer:
  - Load the shift register with din.
  - Register the first bit into x and set x_valid=1.
  - Set the counter to the frame length minus 1.
- SHIFT:
  - Each edge presents the next bit and decrements the counter.
  - When counter=0, the last bit is on x: word_done=1 and din_ready=1.
- Last-bit edge with a transfer (back-to-back):
  - Reload from din, present the new first bit, stay in SHIFT.
  - x_valid stays 1 with no gap.
- Last-bit edge without a transfer:
  - Go to IDLE with x=0, x_valid=0, busy=0.
- Frame length = WIDTH bits (WIDTH+1 with the optional parity feature). The counter is sized for the frame length.
- Bit order follows MSB_FIRST. With MSB_FIRST=1, shift left and send the top bit; with MSB_FIRST=0, shift right and send bit 0.
- In IDLE, x is held at 0 every cycle.
- word_done and busy are registered, aligned with x, and have no combinational path from inputs.

Optional Feature:
- Macro SERIAL_WORD_SHIFTER_PARITY_EN.
- When defined:
  - After the WIDTH data bits, one even-parity bit is sent (XOR of din captured at transfer). The frame is WIDTH+1 bits.
  - word_done and din_ready are asserted on the parity-bit cycle instead of the last data bit.
  - Back-to-back reload is allowed at the parity-bit cycle.
- When undefined:
  - The frame is exactly WIDTH bits.
  - No parity logic or register is present.

Test Plan:
- Basic MSB-first: WIDTH=8, MSB_FIRST=1, din=8'hD0 with one valid pulse → x = 1,1,0,1,0,0,0,0 on 8 consecutive cycles starting 1 cycle after transfer. x_valid=1 for exactly those 8 cycles. word_done only on the 8th. Downstream 1101 detector shows y=1 once.
- Back-to-back: din_valid held high with 8'hD0 then 8'h0D → 16 contiguous x_valid cycles, x = 11010000 00001101. din_ready=1 only on cycle 8 and cycle 16. word_done pulses at 8 and 16.
- Idle fill: din_valid=0 for 10 cycles after reset release → x=0, x_valid=0, busy=0, din_ready=1 throughout.
- Reset mid-word: assert rst=0 after 3 bits of 8'hFF → x, x_valid, busy drop to 0 immediately (asynchronous). After release, no further bits until a new transfer.
- LSB-first: MSB_FIRST=0, din=8'h0B → x = 1,1,0,1,0,0,0,0.
- Parity (macro defined): din=8'hD0 (three 1s) → 9 bits 1,1,0,1,0,0,0,0,1, word_done on the 9th. din=8'hC0 → 9th bit 0.
